// File: rtl/cpu_run_ctrl_if.sv
// Bundle between the debug command path / CPU status block and the run controller.
// Command handshake: a command transfers in any cycle where cmd_valid & cmd_ready are both high.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             cmd_valid;
  logic [2:0]       cmd_code;
  logic [31:0]      cmd_arg;
  logic             cmd_ready;
  logic             stall;
  logic             pc_valid;
  logic [31:0]      pc_ex;
  logic             cpu_start;
  logic             quit_cmd;
  logic             running;
  logic             halt_done;
  logic [1:0]       halt_reason;
  logic             cmd_err;
  logic [CNT_W-1:0] run_cycles;
  logic [1:0]       dbg_state;

  modport master (
    output cmd_valid, cmd_code, cmd_arg, stall, pc_valid, pc_ex,
    input  cmd_ready, cpu_start, quit_cmd, running, halt_done,
           halt_reason, cmd_err, run_cycles, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_arg, stall, pc_valid, pc_ex,
    output cmd_ready, cpu_start, quit_cmd, running, halt_done,
           halt_reason, cmd_err, run_cycles, dbg_state
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller: turns debug start/stop/step/breakpoint commands into paced
// cpu_start / quit_cmd pulses and reports halt reason and executed cycles.
module cpu_run_ctrl #(
  parameter int SETTLE_CYC = 5,
  parameter int CNT_W      = 32
) (
  input logic            clk,
  input logic            rst,
  cpu_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_START_SETTLE = 2'd1,
    S_RUN          = 2'd2,
    S_STOP_SETTLE  = 2'd3
  } state_t;

  localparam logic [2:0] C_NOP    = 3'd0;
  localparam logic [2:0] C_START  = 3'd1;
  localparam logic [2:0] C_STEP   = 3'd2;
  localparam logic [2:0] C_STOP   = 3'd3;
  localparam logic [2:0] C_SET_BP = 3'd4;
  localparam logic [2:0] C_CLR_BP = 3'd5;

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_STOP = 2'd1;
  localparam logic [1:0] R_STEP = 2'd2;
  localparam logic [1:0] R_BP   = 2'd3;

  localparam int            SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  state_t            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [CNT_W-1:0]  step_q, step_d;
  logic              step_mode_q, step_mode_d;
  logic              bp_en_q, bp_en_d;
  logic [31:0]       bp_addr_q, bp_addr_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [1:0]        reason_q, reason_d;
  logic              running_q, running_d;
  logic              cpu_start_q, quit_q, err_q, done_q;
  logic              start_go, halt_go, err_d, done_d;
  logic              accept, stop_cmd, bp_hit, step_exh;
  logic [CNT_W-1:0]  step_arg;

  assign accept   = bus.cmd_valid & bus.cmd_ready;
  assign step_arg = CNT_W'(bus.cmd_arg);
  assign stop_cmd = accept & (bus.cmd_code == C_STOP);
  // Breakpoint and step compares use the registered values, so SET_BP/CLR_BP in RUN act next cycle.
  assign bp_hit   = bp_en_q & bus.pc_valid & ~bus.stall & (bus.pc_ex == bp_addr_q);
  assign step_exh = step_mode_q & ~bus.stall & (step_q == CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    step_d      = step_q;
    step_mode_d = step_mode_q;
    bp_en_d     = bp_en_q;
    bp_addr_d   = bp_addr_q;
    cycles_d    = cycles_q;
    reason_d    = reason_q;
    running_d   = running_q;
    start_go    = 1'b0;
    halt_go     = 1'b0;
    err_d       = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_code)
            C_START: begin
              start_go    = 1'b1;
              step_mode_d = 1'b0;
            end
            C_STEP: begin
              if (step_arg != '0) begin
                start_go    = 1'b1;
                step_mode_d = 1'b1;
                step_d      = step_arg;
              end else begin
                err_d = 1'b1;
              end
            end
            C_SET_BP: begin
              bp_addr_d = bus.cmd_arg;
              bp_en_d   = 1'b1;
            end
            C_CLR_BP: bp_en_d = 1'b0;
            C_NOP:    ;
            default:  err_d = 1'b1;
          endcase
        end
      end

      S_START_SETTLE: begin
        if (settle_q == '0) state_d = S_RUN;
        else                settle_d = settle_q - 1'b1;
      end

      S_RUN: begin
        if (!bus.stall) begin
          cycles_d = cycles_q + CNT_W'(1);
          if (step_mode_q) step_d = step_q - CNT_W'(1);
        end
        if (accept) begin
          case (bus.cmd_code)
            C_SET_BP: begin
              bp_addr_d = bus.cmd_arg;
              bp_en_d   = 1'b1;
            end
            C_CLR_BP:      bp_en_d = 1'b0;
            C_NOP, C_STOP: ;
            default:       err_d = 1'b1;
          endcase
        end
        // Halt priority: STOP command, then breakpoint, then step exhaustion.
        if (stop_cmd) begin
          halt_go  = 1'b1;
          reason_d = R_STOP;
        end else if (bp_hit) begin
          halt_go  = 1'b1;
          reason_d = R_BP;
        end else if (step_exh) begin
          halt_go  = 1'b1;
          reason_d = R_STEP;
        end
        if (halt_go) begin
          state_d   = S_STOP_SETTLE;
          settle_d  = SETTLE_LOAD;
          running_d = 1'b0;
        end
      end

      S_STOP_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start_go) begin
      state_d   = S_START_SETTLE;
      settle_d  = SETTLE_LOAD;
      running_d = 1'b1;
      cycles_d  = '0;
      reason_d  = R_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      step_q      <= '0;
      step_mode_q <= 1'b0;
      bp_en_q     <= 1'b0;
      bp_addr_q   <= '0;
      cycles_q    <= '0;
      reason_q    <= R_NONE;
      running_q   <= 1'b0;
      cpu_start_q <= 1'b0;
      quit_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      step_q      <= step_d;
      step_mode_q <= step_mode_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
      cycles_q    <= cycles_d;
      reason_q    <= reason_d;
      running_q   <= running_d;
      cpu_start_q <= start_go;
      quit_q      <= halt_go;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE) || (state_q == S_RUN);
  assign bus.cpu_start   = cpu_start_q;
  assign bus.quit_cmd    = quit_q;
  assign bus.running     = running_q;
  assign bus.halt_done   = done_q;
  assign bus.halt_reason = reason_q;
  assign bus.cmd_err     = err_q;
  assign bus.run_cycles  = cycles_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: timing of start/stop pulses, step/breakpoint
// halts, halt priority, illegal commands and mid-run reset.
module tb_cpu_run_ctrl;

  localparam int SETTLE = 5;
  localparam logic [2:0] C_NOP = 3'd0, C_START = 3'd1, C_STEP = 3'd2, C_STOP = 3'd3,
                         C_SET_BP = 3'd4, C_CLR_BP = 3'd5;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SSET = 2'd1, ST_RUN = 2'd2, ST_QSET = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] exp_q[$];

  cpu_run_ctrl_if #(.CNT_W(32)) bus ();

  cpu_run_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every halt_done pulse must match the next expected halt reason
  always @(negedge clk) begin
    if (!rst && bus.halt_done) begin
      if (exp_q.size() == 0) check_eq("halt_unexpected", 32'd1, 32'd0);
      else                   check_eq("halt_reason_sb", {30'd0, bus.halt_reason}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [31:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    bus.cmd_arg   = arg;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = C_NOP;
    bus.cmd_arg   = '0;
  endtask

  // called in the cycle right after the accept; returns in the first RUN cycle
  task automatic settle_to_run();
    repeat (SETTLE) tick();
    check_eq("run_entered", {30'd0, bus.dbg_state}, {30'd0, ST_RUN});
  endtask

  // called in the quit_cmd cycle; returns in the halt_done cycle
  task automatic wait_done();
    repeat (SETTLE) tick();
    check_eq("halt_done", {31'd0, bus.halt_done}, 32'd1);
    check_eq("ready_back", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  logic [5:0] stall_pat;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = C_NOP;
    bus.cmd_arg   = '0;
    bus.stall     = 1'b0;
    bus.pc_valid  = 1'b0;
    bus.pc_ex     = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check_eq("rst_state", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    check_eq("rst_running", {31'd0, bus.running}, 32'd0);
    check_eq("rst_reason", {30'd0, bus.halt_reason}, 32'd0);
    check_eq("rst_cycles", bus.run_cycles, 32'd0);

    // START then STOP: accept at t, STOP at t+10
    issue(C_START, 32'd0);
    check_eq("t1_cpu_start", {31'd0, bus.cpu_start}, 32'd1);
    check_eq("t1_running", {31'd0, bus.running}, 32'd1);
    check_eq("t1_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    for (int i = 0; i < SETTLE - 1; i++) begin
      tick();
      check_eq("t1_settle_ready", {31'd0, bus.cmd_ready}, 32'd0);
      check_eq("t1_start_once", {31'd0, bus.cpu_start}, 32'd0);
    end
    tick();
    check_eq("t1_ready_run", {31'd0, bus.cmd_ready}, 32'd1);
    check_eq("t1_state_run", {30'd0, bus.dbg_state}, {30'd0, ST_RUN});
    repeat (4) tick();
    exp_q.push_back(32'd1);
    issue(C_STOP, 32'd0);
    check_eq("t1_quit", {31'd0, bus.quit_cmd}, 32'd1);
    check_eq("t1_running_fall", {31'd0, bus.running}, 32'd0);
    check_eq("t1_cycles", bus.run_cycles, 32'd5);
    check_eq("t1_state_qset", {30'd0, bus.dbg_state}, {30'd0, ST_QSET});
    for (int i = 0; i < SETTLE - 1; i++) begin
      tick();
      check_eq("t1_no_done", {31'd0, bus.halt_done}, 32'd0);
      check_eq("t1_quit_once", {31'd0, bus.quit_cmd}, 32'd0);
    end
    tick();
    check_eq("t1_done", {31'd0, bus.halt_done}, 32'd1);
    check_eq("t1_reason", {30'd0, bus.halt_reason}, 32'd1);
    check_eq("t1_idle", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    tick();
    check_eq("t1_done_pulse", {31'd0, bus.halt_done}, 32'd0);

    // STEP 3, no stalls
    issue(C_STEP, 32'd3);
    check_eq("t2_cpu_start", {31'd0, bus.cpu_start}, 32'd1);
    check_eq("t2_reason_clr", {30'd0, bus.halt_reason}, 32'd0);
    settle_to_run();
    tick();
    check_eq("t2_run2", {31'd0, bus.quit_cmd}, 32'd0);
    tick();
    check_eq("t2_run3", {31'd0, bus.quit_cmd}, 32'd0);
    check_eq("t2_run3_state", {30'd0, bus.dbg_state}, {30'd0, ST_RUN});
    exp_q.push_back(32'd2);
    tick();
    check_eq("t2_quit", {31'd0, bus.quit_cmd}, 32'd1);
    check_eq("t2_cycles", bus.run_cycles, 32'd3);
    check_eq("t2_reason", {30'd0, bus.halt_reason}, 32'd2);
    wait_done();

    // STEP 3 with stall pattern 0,1,1,0,1,0
    stall_pat = 6'b010110;
    issue(C_STEP, 32'd3);
    settle_to_run();
    exp_q.push_back(32'd2);
    for (int i = 0; i < 6; i++) begin
      bus.stall = stall_pat[i];
      tick();
      if (i < 5) check_eq("t3_no_quit", {31'd0, bus.quit_cmd}, 32'd0);
    end
    bus.stall = 1'b0;
    check_eq("t3_quit", {31'd0, bus.quit_cmd}, 32'd1);
    check_eq("t3_cycles", bus.run_cycles, 32'd3);
    wait_done();

    // breakpoint at 0x40: stalled match ignored, live match halts
    issue(C_SET_BP, 32'h40);
    check_eq("t4_setbp_noerr", {31'd0, bus.cmd_err}, 32'd0);
    issue(C_START, 32'd0);
    settle_to_run();
    bus.pc_ex = 32'h40; bus.pc_valid = 1'b1; bus.stall = 1'b1;
    tick();
    check_eq("t4_stall_nohalt", {31'd0, bus.quit_cmd}, 32'd0);
    bus.pc_ex = 32'h44; bus.stall = 1'b0;
    tick();
    check_eq("t4_other_pc", {31'd0, bus.quit_cmd}, 32'd0);
    bus.pc_ex = 32'h40;
    exp_q.push_back(32'd3);
    tick();
    bus.pc_valid = 1'b0;
    check_eq("t4_quit", {31'd0, bus.quit_cmd}, 32'd1);
    check_eq("t4_reason", {30'd0, bus.halt_reason}, 32'd3);
    check_eq("t4_cycles", bus.run_cycles, 32'd2);
    wait_done();

    // STOP + breakpoint + step exhaustion in one cycle; breakpoint persists from before
    issue(C_STEP, 32'd2);
    settle_to_run();
    tick();
    bus.pc_ex = 32'h40; bus.pc_valid = 1'b1;
    exp_q.push_back(32'd1);
    issue(C_STOP, 32'd0);
    bus.pc_valid = 1'b0;
    check_eq("t5_quit", {31'd0, bus.quit_cmd}, 32'd1);
    check_eq("t5_reason", {30'd0, bus.halt_reason}, 32'd1);
    tick();
    check_eq("t5_single_quit", {31'd0, bus.quit_cmd}, 32'd0);
    repeat (SETTLE - 1) tick();
    check_eq("t5_done", {31'd0, bus.halt_done}, 32'd1);

    // illegal commands in IDLE
    issue(C_STEP, 32'd0);
    check_eq("t6_step0_err", {31'd0, bus.cmd_err}, 32'd1);
    check_eq("t6_step0_idle", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    check_eq("t6_step0_nostart", {31'd0, bus.cpu_start}, 32'd0);
    tick();
    check_eq("t6_err_pulse", {31'd0, bus.cmd_err}, 32'd0);
    issue(C_STOP, 32'd0);
    check_eq("t6_stop_err", {31'd0, bus.cmd_err}, 32'd1);
    check_eq("t6_stop_noquit", {31'd0, bus.quit_cmd}, 32'd0);
    issue(3'd7, 32'd0);
    check_eq("t6_code7_err", {31'd0, bus.cmd_err}, 32'd1);
    check_eq("t6_code7_idle", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    check_eq("t6_reason_held", {30'd0, bus.halt_reason}, 32'd1);

    // START while running, then SET_BP in RUN uses old address for the same cycle
    issue(C_START, 32'd0);
    check_eq("t6_start_ok", {31'd0, bus.cmd_err}, 32'd0);
    settle_to_run();
    issue(C_START, 32'd0);
    check_eq("t6_run_start_err", {31'd0, bus.cmd_err}, 32'd1);
    check_eq("t6_run_state", {30'd0, bus.dbg_state}, {30'd0, ST_RUN});
    check_eq("t6_run_nostart", {31'd0, bus.cpu_start}, 32'd0);
    tick();
    check_eq("t6_run_err_pulse", {31'd0, bus.cmd_err}, 32'd0);
    bus.pc_ex = 32'h80; bus.pc_valid = 1'b1;
    issue(C_SET_BP, 32'h80);
    check_eq("t6_bp_old_cmp", {31'd0, bus.quit_cmd}, 32'd0);
    exp_q.push_back(32'd3);
    tick();
    bus.pc_valid = 1'b0;
    check_eq("t6_bp_new_quit", {31'd0, bus.quit_cmd}, 32'd1);
    wait_done();

    // CLR_BP, then reset mid-run clears a breakpoint set during the run
    issue(C_CLR_BP, 32'd0);
    issue(C_START, 32'd0);
    settle_to_run();
    bus.pc_ex = 32'h80; bus.pc_valid = 1'b1;
    tick();
    check_eq("t7_clr_nohalt", {31'd0, bus.quit_cmd}, 32'd0);
    issue(C_SET_BP, 32'h80);
    bus.pc_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t7_rst_state", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    check_eq("t7_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check_eq("t7_rst_running", {31'd0, bus.running}, 32'd0);
    check_eq("t7_rst_quit", {31'd0, bus.quit_cmd}, 32'd0);
    check_eq("t7_rst_cycles", bus.run_cycles, 32'd0);
    check_eq("t7_rst_reason", {30'd0, bus.halt_reason}, 32'd0);
    issue(C_START, 32'd0);
    settle_to_run();
    bus.pc_ex = 32'h80; bus.pc_valid = 1'b1;
    tick();
    check_eq("t7_bp_cleared", {31'd0, bus.quit_cmd}, 32'd0);
    tick();
    check_eq("t7_bp_cleared2", {31'd0, bus.quit_cmd}, 32'd0);
    bus.pc_valid = 1'b0;
    exp_q.push_back(32'd1);
    issue(C_STOP, 32'd0);
    check_eq("t7_quit", {31'd0, bus.quit_cmd}, 32'd1);
    check_eq("t7_cycles", bus.run_cycles, 32'd3);
    wait_done();

    tick();
    check_eq("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
